// File: rtl/csr_access_ctrl.sv
// -----------------------------------------------------------------------------
// csr_access_ctrl
//
// Initiator side of the shared CSR bus. Accepts one Zicsr operation
// (CSRRW / CSRRS / CSRRC with the source operand already resolved) from the
// execute stage. It runs a one-cycle READ phase and, when the write is
// effective and the access is legal, a one-cycle WRITE phase expressed as
// set/clear masks. It then returns the pre-write CSR value, or an
// illegal-instruction flag, to the pipeline.
//
// Ports
//   clk_i          rising-edge clock
//   rst_i          asynchronous, active-low reset
//   req_valid_i    request present            req_ready_o   accepting (IDLE only)
//   req_op_i       01=RW 10=RS 11=RC 00=rsvd  req_addr_i    CSR address
//   req_wdata_i    source operand             req_wr_i      0 = no write (RS/RC)
//   csr_en_o       bus strobe                 csr_addr_o    bus address
//   csr_set_o      bits to set                csr_clear_o   bits to clear
//   csr_read_i     OR-combined read data      csr_ack_i     OR-combined ack
//   rsp_valid_o    response present           rsp_ready_i   response accepted
//   rsp_rdata_o    old CSR value (0 if illegal)
//   rsp_illegal_o  raise illegal-instruction
// -----------------------------------------------------------------------------
module csr_access_ctrl #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        req_op_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    input  logic              req_wr_i,
    output logic              csr_en_o,
    output logic [ADDR_W-1:0] csr_addr_o,
    output logic [DATA_W-1:0] csr_set_o,
    output logic [DATA_W-1:0] csr_clear_o,
    input  logic [DATA_W-1:0] csr_read_i,
    input  logic              csr_ack_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_illegal_o
);

    localparam logic [1:0] OP_RSVD = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;
    localparam logic [1:0] OP_RC   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_READ  = 2'b01,
        S_WRITE = 2'b10,
        S_RESP  = 2'b11
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [1:0]        r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_wr;
    logic [DATA_W-1:0] r_rdata;
    logic              r_illegal;

    logic              w_wr_eff;
    logic              w_ro_space;
    logic              w_illegal;
    logic [DATA_W-1:0] w_set;
    logic [DATA_W-1:0] w_clear;

    // Translate a Zicsr op into {set, clear} masks; set & clear is 0 by construction.
    function automatic logic [2*DATA_W-1:0] op_masks(input logic [1:0]        op,
                                                    input logic [DATA_W-1:0] wdata);
        logic [DATA_W-1:0] set_v;
        logic [DATA_W-1:0] clr_v;
        set_v = {DATA_W{1'b0}};
        clr_v = {DATA_W{1'b0}};
        case (op)
            OP_RW: begin
                set_v = wdata;
                clr_v = ~wdata;
            end
            OP_RS: begin
                set_v = wdata;
            end
            OP_RC: begin
                clr_v = wdata;
            end
            default: begin
                set_v = {DATA_W{1'b0}};
                clr_v = {DATA_W{1'b0}};
            end
        endcase
        return {set_v, clr_v};
    endfunction

    // Legality of the captured request, evaluated against the live ack in READ.
    // CSRRW always writes, even when the decoder cleared req_wr_i.
    always_comb begin
        w_wr_eff   = r_wr | (r_op == OP_RW);
        w_ro_space = (r_addr[ADDR_W-1 -: 2] == 2'b11);
        w_illegal  = (~csr_ack_i) | (r_op == OP_RSVD) | (w_wr_eff & w_ro_space);
        {w_set, w_clear} = op_masks(r_op, r_wdata);
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid_i) begin
                    w_state_nxt = S_READ;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_READ: begin
                if (w_illegal) begin
                    w_state_nxt = S_RESP;
                end else if (w_wr_eff) begin
                    w_state_nxt = S_WRITE;
                end else begin
                    w_state_nxt = S_RESP;
                end
            end
            S_WRITE: begin
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RESP;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Request capture in IDLE and read-phase result capture in READ.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_op      <= 2'b00;
            r_addr    <= {ADDR_W{1'b0}};
            r_wdata   <= {DATA_W{1'b0}};
            r_wr      <= 1'b0;
            r_rdata   <= {DATA_W{1'b0}};
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        r_op    <= req_op_i;
                        r_addr  <= req_addr_i;
                        r_wdata <= req_wdata_i;
                        r_wr    <= req_wr_i;
                    end
                end
                S_READ: begin
                    // Read-before-write: the value returned is the pre-write one.
                    r_rdata   <= w_illegal ? {DATA_W{1'b0}} : csr_read_i;
                    r_illegal <= w_illegal;
                end
                default: begin
                    r_rdata   <= r_rdata;
                    r_illegal <= r_illegal;
                end
            endcase
        end
    end

    // Outputs are decoded purely from registers, so reset forces them at once.
    always_comb begin
        req_ready_o   = 1'b0;
        csr_en_o      = 1'b0;
        csr_addr_o    = {ADDR_W{1'b0}};
        csr_set_o     = {DATA_W{1'b0}};
        csr_clear_o   = {DATA_W{1'b0}};
        rsp_valid_o   = 1'b0;
        rsp_rdata_o   = {DATA_W{1'b0}};
        rsp_illegal_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready_o = 1'b1;
            end
            S_READ: begin
                csr_en_o   = 1'b1;
                csr_addr_o = r_addr;
            end
            S_WRITE: begin
                csr_en_o    = 1'b1;
                csr_addr_o  = r_addr;
                csr_set_o   = w_set;
                csr_clear_o = w_clear;
            end
            S_RESP: begin
                rsp_valid_o   = 1'b1;
                rsp_rdata_o   = r_rdata;
                rsp_illegal_o = r_illegal;
            end
            default: begin
                req_ready_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for csr_access_ctrl.
// A small CSR bank (0x300, 0x340, 0x341 with low 2 bits hard-wired to 0, and
// read-only 0xC00) answers the bus. A directed vector table with hand-computed
// expectations is run first, then a reset-during-WRITE sequence, then random
// operations checked against a value-level reference model.
// -----------------------------------------------------------------------------
module tb_csr_access_ctrl;

    localparam int AW = 12;
    localparam int DW = 32;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [1:0]    req_op_i = 2'b00;
    logic [AW-1:0] req_addr_i = 12'h000;
    logic [DW-1:0] req_wdata_i = 32'h0;
    logic          req_wr_i = 1'b0;
    logic          csr_en_o;
    logic [AW-1:0] csr_addr_o;
    logic [DW-1:0] csr_set_o;
    logic [DW-1:0] csr_clear_o;
    logic [DW-1:0] csr_read_i;
    logic          csr_ack_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b0;
    logic [DW-1:0] rsp_rdata_o;
    logic          rsp_illegal_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_i = ~clk_i;

    csr_access_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_op_i     (req_op_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .req_wr_i     (req_wr_i),
        .csr_en_o     (csr_en_o),
        .csr_addr_o   (csr_addr_o),
        .csr_set_o    (csr_set_o),
        .csr_clear_o  (csr_clear_o),
        .csr_read_i   (csr_read_i),
        .csr_ack_i    (csr_ack_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_illegal_o(rsp_illegal_o)
    );

    // ---------------- CSR bank (environment) ----------------
    function automatic int idx_of(input logic [11:0] a);
        case (a)
            12'h300: return 0;
            12'h340: return 1;
            12'h341: return 2;
            12'hC00: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [31:0] wmask_of(input int i);
        case (i)
            0:       return 32'hFFFF_FFFF;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'hFFFF_FFFC;
            default: return 32'h0000_0000;
        endcase
    endfunction

    logic [31:0] bank_val [4] = '{32'h0000_0000, 32'h0000_0100, 32'h0000_0200, 32'h0000_0055};
    logic [31:0] ref_val  [4] = '{32'h0000_0000, 32'h0000_0100, 32'h0000_0200, 32'h0000_0055};
    int bank_idx;

    assign bank_idx = idx_of(csr_addr_o);

    // Combinational decode/ack and read data of the bank.
    always_comb begin
        csr_ack_i  = 1'b0;
        csr_read_i = 32'h0;
        if (csr_en_o && bank_idx >= 0) begin
            csr_ack_i  = 1'b1;
            csr_read_i = bank_val[bank_idx];
        end
    end

    // Every acked strobe applies set/clear to the writable bits.
    always @(posedge clk_i) begin
        if (csr_en_o && bank_idx >= 0) begin
            bank_val[bank_idx] <= ((((bank_val[bank_idx] & ~csr_clear_o) | csr_set_o))
                                   & wmask_of(bank_idx))
                                | (bank_val[bank_idx] & ~wmask_of(bank_idx));
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference model: Zicsr semantics on whole register values.
    task automatic model(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                         input logic wr, output logic [31:0] r, output logic ill,
                         output int en, output logic [31:0] s, output logic [31:0] c);
        int          i;
        logic        eff;
        logic [31:0] oldv;
        logic [31:0] newv;
        i    = idx_of(addr);
        eff  = wr || (op == 2'b01);
        ill  = (i < 0) || (op == 2'b00) || (eff && addr[11:10] == 2'b11);
        oldv = (i >= 0) ? ref_val[i] : 32'h0;
        r    = ill ? 32'h0 : oldv;
        en   = (!ill && eff) ? 2 : 1;
        s    = 32'h0;
        c    = 32'h0;
        if (en == 2) begin
            if (op == 2'b01)      begin newv = wd;          s = wd; c = ~wd; end
            else if (op == 2'b10) begin newv = oldv | wd;   s = wd;          end
            else                  begin newv = oldv & ~wd;  c = wd;          end
            ref_val[i] = (newv & wmask_of(i)) | (oldv & ~wmask_of(i));
        end
    endtask

    // One full operation: handshake, bus phases, response with backpressure.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [11:0] addr,
                         input logic [31:0] wd, input logic wr, input int delay,
                         input logic [31:0] e_rdata, input logic e_ill, input int e_en,
                         input logic [31:0] e_set, input logic [31:0] e_clr);
        int          cyc;
        int          en_cnt;
        logic [31:0] got_set;
        logic [31:0] got_clr;
        logic [31:0] held;
        check({tag, " ready_idle"}, {31'h0, req_ready_o}, 32'h1);
        req_op_i    = op;
        req_addr_i  = addr;
        req_wdata_i = wd;
        req_wr_i    = wr;
        req_valid_i = 1'b1;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        // cycle 1: READ
        check({tag, " rd_en"},    {31'h0, csr_en_o}, 32'h1);
        check({tag, " rd_addr"},  {20'h0, csr_addr_o}, {20'h0, addr});
        check({tag, " rd_set"},   csr_set_o, 32'h0);
        check({tag, " rd_clr"},   csr_clear_o, 32'h0);
        check({tag, " rd_ready"}, {31'h0, req_ready_o}, 32'h0);
        en_cnt  = csr_en_o ? 1 : 0;
        got_set = 32'h0;
        got_clr = 32'h0;
        cyc     = 1;
        do begin
            @(posedge clk_i); #1;
            cyc++;
            if (csr_en_o) begin
                en_cnt++;
                got_set = csr_set_o;
                got_clr = csr_clear_o;
            end
        end while (!rsp_valid_o && cyc < 8);
        check({tag, " rsp_valid"}, {31'h0, rsp_valid_o}, 32'h1);
        check({tag, " rsp_cycle"}, cyc, (e_en == 2) ? 32'd3 : 32'd2);
        check({tag, " bus_cycles"}, en_cnt, e_en);
        if (e_en == 2) begin
            check({tag, " wr_set"}, got_set, e_set);
            check({tag, " wr_clr"}, got_clr, e_clr);
            check({tag, " set_and_clr"}, got_set & got_clr, 32'h0);
        end
        check({tag, " rdata"},   rsp_rdata_o, e_rdata);
        check({tag, " illegal"}, {31'h0, rsp_illegal_o}, {31'h0, e_ill});
        held = rsp_rdata_o;
        for (int d = 0; d < delay; d++) begin
            @(posedge clk_i); #1;
            check({tag, " hold_valid"}, {31'h0, rsp_valid_o}, 32'h1);
            check({tag, " hold_rdata"}, rsp_rdata_o, held);
            check({tag, " hold_ready"}, {31'h0, req_ready_o}, 32'h0);
            check({tag, " hold_en"},    {31'h0, csr_en_o}, 32'h0);
        end
        rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b0;
        check({tag, " rsp_drop"}, {31'h0, rsp_valid_o}, 32'h0);
        check({tag, " ready_back"}, {31'h0, req_ready_o}, 32'h1);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        wr;
        int          delay;
        logic [31:0] e_rdata;
        logic        e_ill;
        int          e_en;
        logic [31:0] e_set;
        logic [31:0] e_clr;
        logic [31:0] e_new;
    } vec_t;

    vec_t vecs [$];
    logic [11:0] rnd_addrs [6] = '{12'h300, 12'h340, 12'h341, 12'hC00, 12'h7FF, 12'h123};

    initial begin
        logic [31:0] m_r;
        logic        m_ill;
        int          m_en;
        logic [31:0] m_s;
        logic [31:0] m_c;
        int          vi;
        logic [1:0]  r_op_v;
        logic [11:0] r_addr_v;
        logic [31:0] r_wd_v;
        logic        r_wr_v;

        //          op     addr     wdata          wr  dly rdata          ill en set            clr            new
        vecs.push_back('{2'b01, 12'h341, 32'h8000_0104, 1'b1, 0, 32'h0000_0200, 1'b0, 2, 32'h8000_0104, 32'h7FFF_FEFB, 32'h8000_0104});
        vecs.push_back('{2'b10, 12'h341, 32'h0000_0000, 1'b0, 0, 32'h8000_0104, 1'b0, 1, 32'h0, 32'h0, 32'h8000_0104});
        vecs.push_back('{2'b10, 12'h340, 32'h0000_0010, 1'b1, 1, 32'h0000_0100, 1'b0, 2, 32'h0000_0010, 32'h0, 32'h0000_0110});
        vecs.push_back('{2'b11, 12'h340, 32'h0000_0010, 1'b0, 0, 32'h0000_0110, 1'b0, 1, 32'h0, 32'h0, 32'h0000_0110});
        vecs.push_back('{2'b11, 12'h340, 32'h0000_0100, 1'b1, 0, 32'h0000_0110, 1'b0, 2, 32'h0, 32'h0000_0100, 32'h0000_0010});
        vecs.push_back('{2'b01, 12'h7FF, 32'h0000_1234, 1'b1, 0, 32'h0000_0000, 1'b1, 1, 32'h0, 32'h0, 32'h0});
        vecs.push_back('{2'b01, 12'hC00, 32'h0000_FFFF, 1'b1, 0, 32'h0000_0000, 1'b1, 1, 32'h0, 32'h0, 32'h0000_0055});
        vecs.push_back('{2'b10, 12'hC00, 32'h0000_0000, 1'b0, 0, 32'h0000_0055, 1'b0, 1, 32'h0, 32'h0, 32'h0000_0055});
        vecs.push_back('{2'b10, 12'hC00, 32'h0000_0001, 1'b1, 0, 32'h0000_0000, 1'b1, 1, 32'h0, 32'h0, 32'h0000_0055});
        vecs.push_back('{2'b00, 12'h340, 32'h0000_0001, 1'b1, 0, 32'h0000_0000, 1'b1, 1, 32'h0, 32'h0, 32'h0000_0010});
        vecs.push_back('{2'b01, 12'h340, 32'hDEAD_BEEF, 1'b0, 5, 32'h0000_0010, 1'b0, 2, 32'hDEAD_BEEF, 32'h2152_4110, 32'hDEAD_BEEF});

        // Reset state.
        #1;
        check("reset ready", {31'h0, req_ready_o}, 32'h1);
        check("reset en",    {31'h0, csr_en_o}, 32'h0);
        check("reset valid", {31'h0, rsp_valid_o}, 32'h0);
        check("reset rdata", rsp_rdata_o, 32'h0);
        check("reset illegal", {31'h0, rsp_illegal_o}, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i); #1;

        // Directed table.
        for (int k = 0; k < vecs.size(); k++) begin
            model(vecs[k].op, vecs[k].addr, vecs[k].wdata, vecs[k].wr, m_r, m_ill, m_en, m_s, m_c);
            do_op($sformatf("vec%0d", k), vecs[k].op, vecs[k].addr, vecs[k].wdata, vecs[k].wr,
                  vecs[k].delay, vecs[k].e_rdata, vecs[k].e_ill, vecs[k].e_en,
                  vecs[k].e_set, vecs[k].e_clr);
            vi = idx_of(vecs[k].addr);
            if (vi >= 0) check($sformatf("vec%0d newval", k), bank_val[vi], vecs[k].e_new);
        end

        // Reset during WRITE: immediate abort, no write, no response.
        req_op_i    = 2'b01;
        req_addr_i  = 12'h300;
        req_wdata_i = 32'hFFFF_0000;
        req_wr_i    = 1'b1;
        req_valid_i = 1'b1;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        @(posedge clk_i); #1;
        check("rstw wr_en",  {31'h0, csr_en_o}, 32'h1);
        check("rstw wr_set", csr_set_o, 32'hFFFF_0000);
        rst_i = 1'b0;
        #1;
        check("rstw en",    {31'h0, csr_en_o}, 32'h0);
        check("rstw set",   csr_set_o, 32'h0);
        check("rstw clr",   csr_clear_o, 32'h0);
        check("rstw addr",  {20'h0, csr_addr_o}, 32'h0);
        check("rstw ready", {31'h0, req_ready_o}, 32'h1);
        check("rstw valid", {31'h0, rsp_valid_o}, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(posedge clk_i); #1;
            check("rstw post_valid", {31'h0, rsp_valid_o}, 32'h0);
            check("rstw post_en",    {31'h0, csr_en_o}, 32'h0);
        end
        check("rstw no_write", bank_val[0], ref_val[0]);

        // Random operations against the reference model.
        for (int n = 0; n < 40; n++) begin
            r_op_v   = 2'($urandom_range(0, 3));
            r_addr_v = rnd_addrs[$urandom_range(0, 5)];
            r_wd_v   = $urandom;
            r_wr_v   = 1'($urandom_range(0, 1));
            model(r_op_v, r_addr_v, r_wd_v, r_wr_v, m_r, m_ill, m_en, m_s, m_c);
            do_op($sformatf("rnd%0d", n), r_op_v, r_addr_v, r_wd_v, r_wr_v,
                  $urandom_range(0, 3), m_r, m_ill, m_en, m_s, m_c);
            vi = idx_of(r_addr_v);
            if (vi >= 0) check($sformatf("rnd%0d newval", n), bank_val[vi], ref_val[vi]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
